// File: rtl/masked_inv_sbox.sv
// First-order multiplicatively masked AES inverse S-box, 6 enabled cycles of latency.
// One byte per enabled cycle; en=0 freezes every stage, and no other backpressure exists.
module masked_inv_sbox (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [15:0] inp,
  input  logic [18:0] PRNG,
  output logic        out_valid,
  output logic [15:0] SB_out
);

  localparam int LAT = 6;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // a^254 by repeated squaring; only ever fed nonzero operands
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_lin(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]};
  endfunction

  // Two-share AND; bit [1] is share1, bit [0] is share0. Cross terms are re-masked by r.
  function automatic logic [1:0] dom_and(input logic [1:0] x, input logic [1:0] y, input logic r);
    return {(x[1] & y[1]) ^ ((x[1] & y[0]) ^ r),
            (x[0] & y[0]) ^ ((x[0] & y[1]) ^ r)};
  endfunction

  logic [LAT-1:0] r_vld;

  logic [7:0] r_a1_1, r_a0_1;
  logic [7:0] r_a1_2, r_a0_2;
  logic [7:0] r_a1_3, r_a0_3;
  logic [3:0][1:0] r_y2;
  logic [1:0] r_d3, r_d4, r_d5;
  logic [7:0] r_m1_4, r_m0_4, r_r0_4;
  logic [7:0] r_t_5, r_r1_5, r_r0_5;

  logic [7:0] w_s1_a1, w_s1_a0;
  logic [7:0] w_z1, w_z0;
  logic [3:0] w_kr;
  logic [3:0][1:0] w_y;
  logic [1:0] w_u0, w_u1, w_d;
  logic [7:0] w_r0, w_b1, w_b0, w_m1, w_m0;
  logic [7:0] w_p, w_t;
  logic [7:0] w_o1, w_o0;

  // Stage 1: inverse affine, constant folded into share1 only
  assign w_s1_a1 = inv_lin(inp[15:8]) ^ 8'h05;
  assign w_s1_a0 = inv_lin(inp[7:0]);

  // Stage 2: delta(x) = AND of all bits of ~x; inverting share1 alone inverts x
  assign w_z1 = ~r_a1_1;
  assign w_z0 = r_a0_1;
  assign w_kr = {PRNG[16] ^ PRNG[18], PRNG[18], PRNG[17], PRNG[16]};

  always_comb begin
    w_y = '0;
    for (int j = 0; j < 4; j++) begin
      w_y[j] = dom_and({w_z1[2*j],   w_z0[2*j]},
                       {w_z1[2*j+1], w_z0[2*j+1]}, w_kr[j]);
    end
  end

  // Stage 3: reduce the four partial products to one shared delta bit
  assign w_u0 = dom_and(r_y2[0], r_y2[1], PRNG[16]);
  assign w_u1 = dom_and(r_y2[2], r_y2[3], PRNG[17]);
  assign w_d  = dom_and(w_u0, w_u1, PRNG[18]);

  // Stage 4: zero-corrected shares times a nonzero multiplicative mask
  assign w_r0 = (PRNG[7:0] == 8'h00) ? 8'h01 : PRNG[7:0];
  assign w_b1 = r_a1_3 ^ {7'b0, r_d3[1]};
  assign w_b0 = r_a0_3 ^ {7'b0, r_d3[0]};
  assign w_m1 = gf_mul(w_b1, w_r0);
  assign w_m0 = gf_mul(w_b0, w_r0);

  // Stage 5: p is only multiplicatively masked, so the inverse leaves stage re-masked by r1
  assign w_p = r_m1_4 ^ r_m0_4;
  assign w_t = gf_inv(w_p) ^ PRNG[15:8];

  // Stage 6: back to Boolean shares, undoing the zero mapping
  assign w_o1 = gf_mul(r_r0_5, r_t_5)  ^ {7'b0, r_d5[1]};
  assign w_o0 = gf_mul(r_r0_5, r_r1_5) ^ {7'b0, r_d5[0]};

  always_ff @(posedge clk) begin
    if (en) begin
      r_a1_1 <= w_s1_a1;
      r_a0_1 <= w_s1_a0;

      r_a1_2 <= r_a1_1;
      r_a0_2 <= r_a0_1;
      r_y2   <= w_y;

      r_a1_3 <= r_a1_2;
      r_a0_3 <= r_a0_2;
      r_d3   <= w_d;

      r_m1_4 <= w_m1;
      r_m0_4 <= w_m0;
      r_r0_4 <= w_r0;
      r_d4   <= r_d3;

      r_t_5  <= w_t;
      r_r1_5 <= PRNG[15:8];
      r_r0_5 <= r_r0_4;
      r_d5   <= r_d4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      SB_out <= 16'h0000;
    end else if (en) begin
      r_vld  <= {r_vld[LAT-2:0], in_valid};
      SB_out <= {w_o1, w_o0};
    end
  end

  assign out_valid = r_vld[LAT-1];

endmodule

// File: tb/tb_masked_inv_sbox.sv
// Randomized bench for masked_inv_sbox against a table-based inverse S-box model.
module tb_masked_inv_sbox;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] inp = 16'h0;
  logic [18:0] PRNG = 19'h0;
  logic        out_valid;
  logic [15:0] SB_out;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] isb [256];
  logic [8:0] pipe_q [$];
  logic       exp_vld = 1'b0;
  logic [7:0] exp_byte = 8'h00;
  bit         r0_zero = 1'b0;

  always #5 clk = ~clk;

  masked_inv_sbox dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .inp(inp),
    .PRNG(PRNG), .out_valid(out_valid), .SB_out(SB_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition, then inverted as a permutation
  task automatic build_table();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb = 8'(x);
      logic [7:0] iv = 8'h00;
      logic [7:0] s;
      if (x != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(xb, 8'(b)) == 8'h01) iv = 8'(b);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      isb[s] = xb;
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic [7:0] x,
                       input logic [7:0] m, input logic [7:0] exp_b, input logic r);
    rst = r;
    en = e;
    in_valid = v;
    inp = {x ^ m, m};
    PRNG = 19'($urandom);
    if (r0_zero) PRNG[7:0] = 8'h00;
    @(posedge clk);
    #1;
    if (r) begin
      pipe_q.delete();
      exp_vld = 1'b0;
    end else if (e) begin
      pipe_q.push_back({v, exp_b});
      if (pipe_q.size() == LAT) {exp_vld, exp_byte} = pipe_q.pop_front();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'h12, 8'h34, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (SB_out !== 16'h0000) begin
      n_fails++; $display("FAIL reset_sbout got %h want 0000", SB_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256 + LAT; i++) begin
      logic [7:0] x = 8'(i);
      logic v = (i < 256);
      drive(1'b1, v, x, 8'($urandom), isb[x], 1'b0);
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL sweep_valid cyc %0d got %b want %b", i, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL sweep_data got %h want %h", SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
  endtask

  task automatic test_spot();
    logic [7:0] xs [4] = '{8'h63, 8'h7C, 8'h00, 8'hED};
    logic [7:0] es [4] = '{8'h00, 8'h01, 8'h52, 8'h53};
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) drive(1'b1, 1'b1, xs[i], 8'($urandom), es[i], 1'b0);
      else       drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL spot_valid cyc %0d got %b want %b", i, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL spot_data got %h want %h", SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
  endtask

  task automatic test_r0_zero();
    r0_zero = 1'b1;
    for (int i = 0; i < 20 + LAT; i++) begin
      logic [7:0] x = 8'($urandom);
      drive(1'b1, (i < 20), x, 8'($urandom), isb[x], 1'b0);
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL r0zero_valid cyc %0d got %b want %b", i, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL r0zero_data got %h want %h", SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
    r0_zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int seen = 0;
    int flushed = 0;
    int cyc = 0;
    while ((sent < 16 || flushed < LAT + 1) && cyc < 400) begin
      logic e = ($urandom_range(0, 3) != 0);
      logic v = (sent < 16) && ($urandom_range(0, 4) != 0);
      logic [7:0] x = 8'($urandom);
      drive(e, v, x, 8'($urandom), isb[x], 1'b0);
      if (e && v) sent++;
      if (e && sent >= 16 && !v) flushed++;
      if (e && out_valid) seen++;
      cyc++;
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL b2b_valid cyc %0d en %b got %b want %b", cyc, e, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
    n_checks++;
    if (seen !== 16) begin
      n_fails++; $display("FAIL b2b_count got %0d want 16", seen);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x = 8'($urandom);
      drive(1'b1, 1'b1, x, 8'($urandom), isb[x], 1'b0);
    end
    drive(1'b1, 1'b1, 8'h55, 8'h0F, 8'h00, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++; $display("FAIL midrst_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (SB_out !== 16'h0000) begin
      n_fails++; $display("FAIL midrst_sbout got %h want 0000", SB_out);
    end
    for (int i = 0; i < 10 + LAT; i++) begin
      if (i == 10) drive(1'b1, 1'b1, 8'hED, 8'($urandom), 8'h53, 1'b0);
      else         drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL midrst_post_valid cyc %0d got %b want %b", i, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL midrst_post_data got %h want %h", SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fails++; $display("FAIL midrst_new_word got %b want 1", out_valid);
    end
  endtask

  task automatic test_fixed_zero();
    logic [7:0] shares [$];
    int distinct = 0;
    for (int i = 0; i < 16 + LAT; i++) begin
      drive(1'b1, (i < 16), 8'h00, 8'($urandom), 8'h52, 1'b0);
      n_checks++;
      if (out_valid !== exp_vld) begin
        n_fails++; $display("FAIL zero_valid cyc %0d got %b want %b", i, out_valid, exp_vld);
      end
      if (exp_vld) begin
        shares.push_back(SB_out[7:0]);
        n_checks++;
        if ((SB_out[15:8] ^ SB_out[7:0]) !== exp_byte) begin
          n_fails++; $display("FAIL zero_data got %h want %h", SB_out[15:8] ^ SB_out[7:0], exp_byte);
        end
      end
    end
    for (int i = 0; i < shares.size(); i++) begin
      bit dup = 1'b0;
      for (int j = 0; j < i; j++) if (shares[j] == shares[i]) dup = 1'b1;
      if (!dup) distinct++;
    end
    n_checks++;
    if (distinct < 2) begin
      n_fails++; $display("FAIL zero_shares_vary got %0d distinct want >=2", distinct);
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_sweep();
    test_spot();
    test_r0_zero();
    test_back_to_back();
    test_reset_midflight();
    test_fixed_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/masked_inv_sbox.md
Name: masked_inv_sbox

Overview:
- First-order multiplicatively masked AES inverse S-box, used by the decryption datapath.
- Takes a byte as two Boolean shares and applies the inverse affine map to each share.
- Converts Boolean to multiplicative masking, with Kronecker-delta zero correction, inverts in GF(2^8), then converts back to Boolean shares.
- Fully pipelined with a valid/enable handshake, so one new byte can be accepted every enabled cycle.

Parameters:
- LAT, 6: pipeline latency in enabled cycles. Fixed; the bench reads it, it is not for overriding.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: pipeline advance enable. When low, all stages hold their contents.
- in_valid, input, 1: `inp` carries a byte this cycle.
- inp, input, 16: {share1, share0}. The unmasked byte is share1 ^ share0.
- PRNG, input, 19: fresh randomness every cycle.
  - [7:0] r0, the multiplicative mask.
  - [15:8] r1, the re-sharing mask.
  - [18:16] Kronecker randomness.
- out_valid, output, 1: `SB_out` carries a result.
- SB_out, output, 16: {out1, out0}. out1 ^ out0 = InvSbox(share1 ^ share0).

Behaviour:
- Reset:
  - The valid shift chain clears, so out_valid = 0 on the first cycle after rst.
  - SB_out = 16'h0000.
  - Internal data registers are not reset. They hold masked values only.
- rst takes priority over en and in_valid on the same edge.
- Reset mid-operation discards every in-flight byte: no out_valid may appear for words accepted before rst.
- Pipeline advance:
  - Every stage and the valid chain move only when en = 1.
  - With en = 0, SB_out and out_valid hold their values.
- Latency: a byte accepted at enabled edge k appears with out_valid = 1 after enabled edge k+LAT-1, i.e. it is visible after LAT enabled edges.
- Throughput: one byte per enabled cycle. No backpressure beyond `en`.
- Bubbles: in_valid = 0 inserts a bubble. Its data flows through but out_valid stays 0 for it.
- Stage 1, inverse affine:
  - Apply the inverse affine linear part L^-1 (rot1 ^ rot3 ^ rot6) to each share.
  - XOR 8'h05 into share1 only.
  - Register the result, and start the Kronecker delta(x) on the shares using PRNG[18:16].
- Stages 2-3, Kronecker delta:
  - Kronecker logic produces a masked 2-share delta after 2 more registers.
  - Share data is delayed in lockstep.
  - The delta shares are XORed into bit 0 of the respective share, which maps a zero input to 1.
  - The delta shares are also carried forward for stage 6.
- Stage 4, Boolean to multiplicative:
  - r0 = PRNG[7:0]; if PRNG[7:0] == 0, use r0 = 8'h01. r0 is never 0.
  - Compute b1*r0 and b0*r0 in GF(2^8), with polynomial x^8+x^4+x^3+x+1.
  - Register both products and r0 separately. The products are XORed only after the register.
- Stage 5, inversion and re-sharing:
  - p = b1*r0 ^ b0*r0.
  - Compute inv(p), then inv(p) ^ r1.
  - Register that value, r1, and r0.
- Stage 6, multiplicative to Boolean:
  - out1' = r0 * (inv(p) ^ r1).
  - out0' = r0 * r1.
  - XOR the respective delta share into bit 0 of each, which undoes the zero mapping.
  - Register into SB_out.
- Share separation: no register may hold a value combining share0 and share1 unmasked.
- Randomness: each PRNG field is consumed in the cycle its stage needs it. Reusing a PRNG value across words must not affect correctness, only security.
- Wrap-around: none. The block is stateless apart from the pipeline.

Test Plan:
- Random sweep: all 256 x with random mask m (inp = {x^m, m}) and random PRNG each cycle. After LAT enabled cycles, SB_out[15:8] ^ SB_out[7:0] == InvSbox(x).
- Spot values:
  - x = 0x63 gives 0x00 (exercises the zero path through Kronecker).
  - x = 0x7C gives 0x01.
  - x = 0x00 gives 0x52.
  - x = 0xED gives 0x53.
- PRNG[7:0] forced to 0 for 20 words: results are still correct, since r0 is mapped to 0x01.
- Back-to-back stream of 16 words with random en gaps: out_valid pattern equals the in_valid pattern delayed by 6 enabled edges. Order is preserved and outputs hold while en = 0.
- Assert rst while 4 words are in flight: out_valid = 0 and SB_out = 0 the next cycle. No stale word ever emerges, and a new word after rst completes in 6 cycles.
- Fixed x = 0x00 with varying m and PRNG: shares change every run while the recombined output is always 0x52.
